// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared types and constants for the serial adder
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// half_adder : one-bit half adder
// Revision 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial adder, LSB first, with valid/ready handshakes
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ha0_s, ha0_c;
  logic               bit_s, ha1_c;
  logic               bit_c;

  // Full adder from two half adders; carry is the OR of both partial carries.
  half_adder u_ha0 (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .a (ha0_s),
    .b (c_q),
    .s (bit_s),
    .c (ha1_c)
  );

  assign bit_c = ha0_c | ha1_c;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_d      = c_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = bit_s;
        c_d                 = bit_c;
        cnt_d               = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_d;
          carry_d = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : self-checking bench for serial_adder (WIDTH = 8)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_c;
  } vec_t;

  vec_t vecs [6];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit integer addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One full transaction: returns to IDLE afterwards.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] es, input logic ec, input int hold);
    int n;
    int bad;
    wait_ready();
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~xa;
    b        = ~xb;
    n   = 0;
    bad = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) bad++;
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd8);
    check("busy_in_ready_low", 32'(bad), 32'd0);
    check("out_valid", 32'(out_valid), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("carry_out", 32'(carry_out), 32'(ec));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(es));
      check("hold_carry", 32'(carry_out), 32'(ec));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("idle_sum_kept", 32'(sum), 32'(es));
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    int n;
    int seen;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 8'h46, 1'b0};

    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);

    // Directed table; first entry exercises 5-cycle backpressure.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_c, (i == 0) ? 5 : 1);
    end

    // in_valid held high across a whole operation: second pair only after IDLE.
    out_ready = 1'b1;
    a = 8'h55; b = 8'h01; in_valid = 1'b1;
    tick();
    a = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      check("hold_iv_busy_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    check("hold_iv_first_valid", 32'(out_valid), 32'd1);
    check("hold_iv_first_sum", 32'(sum), 32'h56);
    tick();
    check("hold_iv_idle", 32'(in_ready), 32'd1);
    tick();
    check("hold_iv_second_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("hold_iv_second_valid", 32'(out_valid), 32'd1);
    check("hold_iv_second_sum", 32'(sum), 32'hAB);
    tick();
    out_ready = 1'b0;

    // Reset at BUSY bit 4 aborts the operation with no output.
    run_op(8'h70, 8'h91, 8'h01, 1'b1, 1);
    wait_ready();
    a = 8'h3C; b = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_output", 32'(seen), 32'd0);

    // Randomised operands against the arithmetic reference.
    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      r  = ref_add(ra, rb);
      run_op(ra, rb, r[W-1:0], r[W], int'($urandom_range(0, 3)));
    end

    // Output accepted immediately in DONE; check minimum period of W+2.
    out_ready = 1'b1;
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    tick();
    n = 1;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("min_period", 32'(n), 32'(W + 2));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("min_period_sum", 32'(sum), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
